// File: rtl/mem_pkg.sv
// Shared constants and types for the two-master memory arbiter.
package mem_pkg;

    localparam int MEM_WIDTH   = 16;
    localparam int MEM_DEPTH   = 64;
    localparam int MEM_TIMEOUT = 16;

    // Arbiter FSM encoding, kept as plain constants for older tool flows.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_RESP  = 2'd2;

    // Requester index: 0 = m0, 1 = m1.
    typedef logic grant_id_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time goes next.
module rr_pick2
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       any
);

    // Tie alternates against the previous winner; a lone request simply wins.
    always_comb begin
        any = |req;
        gnt = 1'b0;
        if (req == 2'b11) begin
            gnt = ~last;
        end else if (req[1]) begin
            gnt = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between two requesters, one transaction at a time.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transaction; pick a winner from m0/m1 and latch its command
// ST_ISSUE | drive latched command to memory until ready or timeout
// ST_RESP  | one-cycle ready/err pulse to the granted requester
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int WIDTH      = MEM_WIDTH,
    parameter int DEPTH      = MEM_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = MEM_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_valid,
    input  logic                  m0_wr_rd,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [WIDTH-1:0]      m0_wdata,
    output logic                  m0_ready,
    output logic                  m0_err,
    output logic [WIDTH-1:0]      m0_rdata,
    input  logic                  m1_valid,
    input  logic                  m1_wr_rd,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [WIDTH-1:0]      m1_wdata,
    output logic                  m1_ready,
    output logic                  m1_err,
    output logic [WIDTH-1:0]      m1_rdata,
    output logic                  valid,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH-1:0]      rdata,
    input  logic                  ready
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                state_q, state_d;
    grant_id_t             grant_q, grant_d;
    grant_id_t             last_q, last_d;
    logic                  ok_q, ok_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic pick_gnt;
    logic pick_any;
    logic in_issue;
    logic in_resp;

    rr_pick2 u_pick (
        .req  ({m1_valid, m0_valid}),
        .last (last_q),
        .gnt  (pick_gnt),
        .any  (pick_any)
    );

    // Next-state and latch updates; the command is captured once at grant and never re-read.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        ok_d    = ok_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_ISSUE;
                    grant_d = pick_gnt;
                    cnt_d   = '0;
                    if (pick_gnt) begin
                        wr_d    = m1_wr_rd;
                        addr_d  = m1_addr;
                        wdata_d = m1_wdata;
                    end else begin
                        wr_d    = m0_wr_rd;
                        addr_d  = m0_addr;
                        wdata_d = m0_wdata;
                    end
                end
            end
            ST_ISSUE: begin
                if (ready) begin
                    state_d = ST_RESP;
                    ok_d    = 1'b1;
                    if (!wr_q) begin
                        rdata_d = rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                    ok_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                last_d  = grant_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register bank; reset abandons any transaction without a response pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            ok_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            ok_q    <= ok_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_issue = (state_q == ST_ISSUE);
    assign in_resp  = (state_q == ST_RESP);

    // Memory side is quiet (all zero) whenever no command is being issued.
    assign valid = in_issue;
    assign wr_rd = in_issue & wr_q;
    assign addr  = in_issue ? addr_q : '0;
    assign wdata = in_issue ? wdata_q : '0;

    // Only the granted requester sees anything, and only during the response cycle.
    assign m0_ready = in_resp & ~grant_q & ok_q;
    assign m0_err   = in_resp & ~grant_q & ~ok_q;
    assign m0_rdata = (in_resp & ~grant_q) ? rdata_q : '0;
    assign m1_ready = in_resp & grant_q & ok_q;
    assign m1_err   = in_resp & grant_q & ~ok_q;
    assign m1_rdata = (in_resp & grant_q) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: the bench plays both requesters and the memory, and predicts
// every transaction as a timeline (grant edge, issue length, response edge).
module tb_mem_arbiter;

    localparam int WIDTH = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int TO    = 16;

    logic clk = 1'b0;
    logic rst;
    logic m0_valid, m0_wr_rd, m0_ready, m0_err;
    logic [AW-1:0] m0_addr;
    logic [WIDTH-1:0] m0_wdata, m0_rdata;
    logic m1_valid, m1_wr_rd, m1_ready, m1_err;
    logic [AW-1:0] m1_addr;
    logic [WIDTH-1:0] m1_wdata, m1_rdata;
    logic valid, wr_rd, ready;
    logic [AW-1:0] addr;
    logic [WIDTH-1:0] wdata, rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_wr_rd(m0_wr_rd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_wr_rd(m1_wr_rd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready)
    );

    int vectors = 0;
    int miscompares = 0;

    // requester side: mode 0 one-shot, 1 re-raise same command, 2 random arrivals
    logic rv[2];
    logic rwr[2];
    logic [AW-1:0] raddr[2];
    logic [WIDTH-1:0] rwd[2];
    int rmode[2];
    bit scramble_en = 0;
    bit spurious_rdy_en = 1;
    bit rand_rst_en = 0;
    bit force_rst = 0;
    int lat_fixed = 1;

    assign m0_valid = rv[0];
    assign m0_wr_rd = rwr[0];
    assign m0_addr  = raddr[0];
    assign m0_wdata = rwd[0];
    assign m1_valid = rv[1];
    assign m1_wr_rd = rwr[1];
    assign m1_addr  = raddr[1];
    assign m1_wdata = rwd[1];

    // timeline model
    logic [WIDTH-1:0] mem_m [DEPTH];
    int e = 0;
    bit act = 0;
    int g = 0;
    int e_g = 0;
    int n_iss = 0;
    int lat_cur = 0;
    bit last_m = 1;
    bit wr_m = 0;
    logic [AW-1:0] addr_m = '0;
    logic [WIDTH-1:0] wd_m = '0;
    logic [WIDTH-1:0] rd_m = '0;
    bit x_valid = 0;
    bit x_pulse = 0;
    bit x_ok = 0;
    int x_g = 0;

    // observations of DUT pulses, used by the literal checks
    int valid_cnt;
    int rdy_cnt[2];
    int err_cnt[2];
    logic [WIDTH-1:0] last_rdata[2];
    int order_q[$];
    logic [AW-1:0] addr_q[$];

    task automatic expect_int(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic clear_obs();
        valid_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            rdy_cnt[i] = 0;
            err_cnt[i] = 0;
            last_rdata[i] = '0;
        end
        order_q.delete();
        addr_q.delete();
    endtask

    task automatic check_cycle();
        bit bad;
        bit pr[2];
        bit pe[2];
        logic [WIDTH-1:0] drd[2];
        bad = 0;
        vectors++;
        for (int i = 0; i < 2; i++) begin
            pr[i] = x_pulse && (x_g == i) && x_ok;
            pe[i] = x_pulse && (x_g == i) && !x_ok;
        end
        drd[0] = m0_rdata;
        drd[1] = m1_rdata;
        if (valid !== x_valid) begin
            $display("FAIL valid e=%0d got %b want %b", e, valid, x_valid); bad = 1;
        end
        if (x_valid) begin
            if (wr_rd !== wr_m) begin
                $display("FAIL wr_rd e=%0d got %b want %b", e, wr_rd, wr_m); bad = 1;
            end
            if (addr !== addr_m) begin
                $display("FAIL addr e=%0d got %0d want %0d", e, addr, addr_m); bad = 1;
            end
            if (wdata !== wd_m) begin
                $display("FAIL wdata e=%0d got %h want %h", e, wdata, wd_m); bad = 1;
            end
        end
        if (m0_ready !== pr[0] || m0_err !== pe[0]) begin
            $display("FAIL m0 pulses e=%0d got rdy=%b err=%b want rdy=%b err=%b",
                     e, m0_ready, m0_err, pr[0], pe[0]); bad = 1;
        end
        if (m1_ready !== pr[1] || m1_err !== pe[1]) begin
            $display("FAIL m1 pulses e=%0d got rdy=%b err=%b want rdy=%b err=%b",
                     e, m1_ready, m1_err, pr[1], pe[1]); bad = 1;
        end
        for (int i = 0; i < 2; i++) begin
            if (pr[i] && !wr_m && drd[i] !== rd_m) begin
                $display("FAIL m%0d_rdata e=%0d got %h want %h", i, e, drd[i], rd_m); bad = 1;
            end
            if (!pr[i] && !pe[i] && drd[i] !== '0) begin
                $display("FAIL m%0d_rdata idle e=%0d got %h want 0", i, e, drd[i]); bad = 1;
            end
        end
        if (bad) miscompares++;
        if (valid === 1'b1) begin
            valid_cnt++;
            addr_q.push_back(addr);
        end
        if (m0_ready === 1'b1) begin rdy_cnt[0]++; last_rdata[0] = m0_rdata; order_q.push_back(0); end
        if (m1_ready === 1'b1) begin rdy_cnt[1]++; last_rdata[1] = m1_rdata; order_q.push_back(1); end
        if (m0_err === 1'b1) err_cnt[0]++;
        if (m1_err === 1'b1) err_cnt[1]++;
    endtask

    // Drive inputs for upcoming edge e and advance the timeline model through that edge.
    task automatic step();
        bit rst_in;
        rst_in = !(force_rst || (rand_rst_en && $urandom_range(0, 299) == 0));
        force_rst = 0;
        for (int i = 0; i < 2; i++) begin
            if (act && g == i && e == e_g + n_iss + 1) begin
                rv[i] = 1'b0;
            end else if (act && g == i && e > e_g) begin
                if (scramble_en) begin
                    rwr[i]   = 1'($urandom_range(0, 1));
                    raddr[i] = AW'($urandom);
                    rwd[i]   = WIDTH'($urandom);
                end
            end else if (!rv[i]) begin
                if (rmode[i] == 1) begin
                    rv[i] = 1'b1;
                end else if (rmode[i] == 2 && $urandom_range(0, 2) == 0) begin
                    rv[i]    = 1'b1;
                    rwr[i]   = 1'($urandom_range(0, 1));
                    raddr[i] = AW'($urandom_range(0, 7));
                    rwd[i]   = WIDTH'($urandom);
                end
            end
        end
        ready = 1'b0;
        rdata = WIDTH'($urandom);
        if (act && e > e_g && e <= e_g + n_iss) begin
            if (e == e_g + lat_cur && lat_cur <= TO) begin
                ready = 1'b1;
                if (!wr_m) rdata = mem_m[addr_m];
            end
        end else if (spurious_rdy_en) begin
            ready = ($urandom_range(0, 3) == 0);
        end
        rst = rst_in;

        x_pulse = 0;
        if (!rst_in) begin
            act = 0;
            last_m = 1;
            x_valid = 0;
        end else begin
            if (act && e == e_g + n_iss) begin
                x_pulse = 1;
                x_g = g;
                x_ok = (lat_cur <= TO);
                if (x_ok) begin
                    if (wr_m) mem_m[addr_m] = wd_m;
                    else rd_m = rdata;
                end
            end
            if (act && e == e_g + n_iss + 1) begin
                act = 0;
                last_m = (g == 1);
            end else if (!act && (rv[0] || rv[1])) begin
                if (rv[0] && rv[1]) g = last_m ? 0 : 1;
                else g = rv[0] ? 0 : 1;
                wr_m    = rwr[g];
                addr_m  = raddr[g];
                wd_m    = rwd[g];
                e_g     = e;
                lat_cur = (lat_fixed >= 0) ? lat_fixed : $urandom_range(1, 20);
                n_iss   = (lat_cur < TO) ? lat_cur : TO;
                act     = 1;
            end
            x_valid = act && (e < e_g + n_iss);
        end
        e++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            step();
            @(posedge clk);
            @(negedge clk);
            check_cycle();
        end
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            force_rst = 1;
            run(1);
        end
    endtask

    task automatic wait_done(input int i, input int budget);
        int start;
        int k;
        start = rdy_cnt[i] + err_cnt[i];
        k = 0;
        while (rdy_cnt[i] + err_cnt[i] == start && k < budget) begin
            run(1);
            k++;
        end
        if (k >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_done m%0d: got no response within %0d cycles, want one", i, budget);
        end
    endtask

    task automatic set_cmd(input int i, input bit w, input int a, input logic [WIDTH-1:0] d);
        rwr[i]   = w;
        raddr[i] = AW'(a);
        rwd[i]   = d;
    endtask

    initial begin
        int bad;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        rst = 1'b0;
        ready = 1'b0;
        rdata = '0;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0;
            rmode[i] = 0;
            set_cmd(i, 0, 0, '0);
        end
        clear_obs();
        @(negedge clk);
        do_reset(2);
        expect_int("reset valid", int'(valid), 0);
        expect_int("reset m0_rdata", int'(m0_rdata), 0);
        expect_int("reset m1 pulses", int'(m1_ready) + int'(m1_err), 0);

        // single write, memory answers on the first issue edge
        clear_obs();
        lat_fixed = 1;
        set_cmd(0, 1, 5, 16'hA5A5);
        rv[0] = 1'b1;
        wait_done(0, 30);
        run(2);
        expect_int("write valid cycles", valid_cnt, 1);
        expect_int("write m0_ready pulses", rdy_cnt[0], 1);
        expect_int("write m0_err pulses", err_cnt[0], 0);

        // readback through the other requester
        clear_obs();
        lat_fixed = 2;
        set_cmd(1, 0, 5, 16'h0000);
        rv[1] = 1'b1;
        wait_done(1, 30);
        run(2);
        expect_int("readback m1_ready", rdy_cnt[1], 1);
        expect_int("readback m1_rdata", int'(last_rdata[1]), 16'hA5A5);
        expect_int("readback m0 silent", rdy_cnt[0] + err_cnt[0], 0);

        // contention straight out of reset
        do_reset(1);
        clear_obs();
        lat_fixed = 1;
        set_cmd(0, 0, 1, 16'h1111);
        set_cmd(1, 0, 2, 16'h2222);
        rmode[0] = 1;
        rmode[1] = 1;
        rv[0] = 1'b1;
        rv[1] = 1'b1;
        for (int k = 0; k < 60 && order_q.size() < 4; k++) run(1);
        rmode[0] = 0;
        rmode[1] = 0;
        run(20);
        expect_int("contention txns", (order_q.size() >= 4) ? 4 : order_q.size(), 4);
        if (order_q.size() >= 4) begin
            expect_int("grant order 0", order_q[0], 0);
            expect_int("grant order 1", order_q[1], 1);
            expect_int("grant order 2", order_q[2], 0);
            expect_int("grant order 3", order_q[3], 1);
        end

        // timeout with memory never answering
        clear_obs();
        lat_fixed = 100;
        set_cmd(0, 0, 3, 16'h0000);
        rv[0] = 1'b1;
        wait_done(0, 40);
        run(2);
        expect_int("timeout valid cycles", valid_cnt, 16);
        expect_int("timeout m0_err", err_cnt[0], 1);
        expect_int("timeout m0_ready", rdy_cnt[0], 0);

        // reset in the middle of ISSUE, then the held request is served
        clear_obs();
        lat_fixed = 100;
        set_cmd(0, 1, 9, 16'h1234);
        rv[0] = 1'b1;
        run(5);
        do_reset(1);
        expect_int("mid reset valid", int'(valid), 0);
        expect_int("mid reset no pulse", rdy_cnt[0] + err_cnt[0], 0);
        lat_fixed = 2;
        wait_done(0, 30);
        run(2);
        expect_int("after reset m0_ready", rdy_cnt[0], 1);
        expect_int("after reset m0_err", err_cnt[0], 0);

        // requester inputs churn while granted; memory command must not move
        clear_obs();
        lat_fixed = 8;
        scramble_en = 1;
        set_cmd(0, 0, 7, 16'h0000);
        rv[0] = 1'b1;
        wait_done(0, 30);
        run(2);
        scramble_en = 0;
        expect_int("stable valid cycles", valid_cnt, 8);
        bad = 0;
        foreach (addr_q[k]) if (addr_q[k] !== 6'd7) bad++;
        expect_int("stable addr", bad, 0);

        // random traffic, random latencies incl. timeouts, spurious ready and resets
        clear_obs();
        lat_fixed = -1;
        scramble_en = 1;
        rand_rst_en = 1;
        rmode[0] = 2;
        rmode[1] = 2;
        run(4000);
        rmode[0] = 0;
        rmode[1] = 0;
        rand_rst_en = 0;
        run(60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
